seq_alu: RTL and testbench



---
 rtl/seq_alu.sv | 208 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: clocked add/sub/mult/div/mod unit with a start/busy/done handshake.
//
// A request is accepted when start=1 while the unit is idle. The command and
// both operands are captured at that edge. GND, ADD, SUB, illegal opcodes and
// division by zero finish in one cycle. MULT, DIV and MOD run WIDTH
// iterations of a shift-add multiplier or a restoring divider.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request strobe, sampled only while idle
//   command  opcode: 0 GND, 1 ADD, 2 SUB, 3 MULT, 4 DIV, 5 MOD, 6-15 illegal
//   inputA   operand A (WIDTH bits)
//   inputB   operand B (WIDTH bits)
//   busy     high while an operation is in flight (CALC and DONE)
//   done     one-cycle pulse; result and error are valid
//   result   2*WIDTH-bit registered result, held until the next completion
//   error    registered error flag, held with result
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         command,
    input  logic [WIDTH-1:0]   inputA,
    input  logic [WIDTH-1:0]   inputB,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               error
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_GND  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_MULT = 4'd3,
        OP_DIV  = 4'd4,
        OP_MOD  = 4'd5
    } op_t;

    state_t state, state_nxt;

    logic [3:0]         op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;

    logic accept;
    logic is_long;
    logic last_iter;

    logic [2*WIDTH-1:0] fast_result;
    logic               fast_error;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff_w;

    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;

    assign accept    = start && (state == IDLE);
    assign last_iter = (state == CALC) && (cnt == CW'(WIDTH - 1));

    // Division by zero is resolved immediately instead of entering CALC.
    always_comb begin
        is_long = 1'b0;
        case (command)
            OP_MULT:        is_long = 1'b1;
            OP_DIV, OP_MOD: is_long = (inputB != '0);
            default:        is_long = 1'b0;
        endcase
    end

    // Single-cycle results, computed straight from the inputs at acceptance.
    always_comb begin
        sum         = inputA + inputB;
        diff_w      = inputA - inputB;
        fast_result = '0;
        fast_error  = 1'b0;
        case (command)
            OP_GND: begin
                fast_result = '0;
                fast_error  = 1'b0;
            end
            OP_ADD: begin
                fast_result = {{WIDTH{sum[WIDTH-1]}}, sum};
                fast_error  = (inputA[WIDTH-1] == inputB[WIDTH-1]) &&
                              (sum[WIDTH-1] != inputA[WIDTH-1]);
            end
            OP_SUB: begin
                fast_result = {{WIDTH{diff_w[WIDTH-1]}}, diff_w};
                fast_error  = (inputA[WIDTH-1] != inputB[WIDTH-1]) &&
                              (diff_w[WIDTH-1] != inputA[WIDTH-1]);
            end
            default: begin
                // Illegal opcodes and DIV/MOD by zero.
                fast_result = '0;
                fast_error  = 1'b1;
            end
        endcase
    end

    // One iteration of each datapath. The final iteration's next values feed
    // the result register directly so done follows the WIDTH-th iteration.
    always_comb begin
        acc_nxt = mplier[0] ? (acc + mcand) : acc;
        rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial   = rem_sh - {1'b0, divisor};
        // trial[WIDTH] set means the subtraction borrowed: restore.
        rem_nxt = trial[WIDTH] ? rem_sh : trial;
        quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = is_long ? CALC : DONE;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            result  <= '0;
            error   <= 1'b0;
        end else if (accept) begin
            op_q    <= command;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, inputA};
            mplier  <= inputB;
            rem     <= '0;
            quo     <= inputA;
            divisor <= inputB;
            if (!is_long) begin
                result <= fast_result;
                error  <= fast_error;
            end
        end else if (state == CALC) begin
            cnt    <= cnt + CW'(1);
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_nxt;
            quo    <= quo_nxt;
            if (last_iter) begin
                error <= 1'b0;
                case (op_q)
                    OP_MULT: result <= acc_nxt;
                    OP_DIV:  result <= {{WIDTH{1'b0}}, quo_nxt};
                    default: result <= {{WIDTH{1'b0}}, rem_nxt[WIDTH-1:0]};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
`timescale 1ns/1ps
module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  command;
    logic [15:0] inputA;
    logic [15:0] inputB;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        error;

    int checks;
    int errors;

    seq_alu #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .command (command),
        .inputA  (inputA),
        .inputB  (inputB),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request (waiting for idle first), scramble the inputs after
    // acceptance, then measure latency to done and check the outputs.
    task automatic run_op(input string tag, input logic [3:0] cmd,
                          input logic [15:0] a, input logic [15:0] b,
                          input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_err, input bit poke);
        int lat;
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_idle"}, 64'(busy), 64'(1'b0));
        command = cmd;
        inputA  = a;
        inputB  = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        command = 4'd1;
        inputA  = 16'h5A5A;
        inputB  = 16'h0003;
        lat = 1;
        while (!done && lat < 100) begin
            chk({tag, "_busy"}, 64'(busy), 64'(1'b1));
            if (poke && lat == 5) start = 1'b1;
            else start = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, 64'(result), 64'(exp_res));
        chk({tag, "_err"}, 64'(error), 64'(exp_err));
        chk({tag, "_busydone"}, 64'(busy), 64'(1'b1));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(done), 64'(1'b0));
        chk({tag, "_hold"}, 64'(result), 64'(exp_res));
        chk({tag, "_idle2"}, 64'(busy), 64'(1'b0));
        if (poke) begin
            // A start seen mid-operation must not have been queued.
            @(posedge clk);
            #1;
            chk({tag, "_noqueue"}, 64'(busy), 64'(1'b0));
        end
    endtask

    initial begin
        int pulses;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        command = 4'd0;
        inputA  = '0;
        inputB  = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_res", 64'(result), 64'(0));
        chk("rst_err", 64'(error), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_ovf", 4'd1, 16'h7FFF, 16'h0001, 1, 32'hFFFF8000, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle clears the held outputs at once.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'(1'b0));
        chk("arst_done", 64'(done), 64'(1'b0));
        chk("arst_res", 64'(result), 64'(0));
        chk("arst_err", 64'(error), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add",     4'd1, 16'd255,  16'd127, 1, 32'd382,      1'b0, 1'b0);
        run_op("sub",     4'd2, 16'd100,  16'd200, 1, 32'hFFFFFF9C, 1'b0, 1'b0);
        run_op("sub_ovf", 4'd2, 16'h8000, 16'h0001, 1, 32'h00007FFF, 1'b1, 1'b0);
        run_op("gnd",     4'd0, 16'h1234, 16'h5678, 1, 32'd0,        1'b0, 1'b0);
        run_op("mult",    4'd3, 16'hFFFF, 16'hFFFF, 17, 32'hFFFE0001, 1'b0, 1'b1);
        run_op("mult2",   4'd3, 16'd300,  16'd7,   17, 32'd2100,     1'b0, 1'b0);
        run_op("mult0",   4'd3, 16'h1234, 16'd0,   17, 32'd0,        1'b0, 1'b0);
        run_op("div",     4'd4, 16'd1000, 16'd7,   17, 32'd142,      1'b0, 1'b0);
        run_op("mod",     4'd5, 16'd1000, 16'd7,   17, 32'd6,        1'b0, 1'b0);
        run_op("div_sm",  4'd4, 16'd5,    16'd9,   17, 32'd0,        1'b0, 1'b0);
        run_op("mod_sm",  4'd5, 16'd5,    16'd9,   17, 32'd5,        1'b0, 1'b0);
        run_op("div_max", 4'd4, 16'hFFFF, 16'd1,   17, 32'h0000FFFF, 1'b0, 1'b0);
        run_op("div0",    4'd4, 16'd1000, 16'd0,   1, 32'd0,        1'b1, 1'b0);
        run_op("mod0",    4'd5, 16'd1000, 16'd0,   1, 32'd0,        1'b1, 1'b0);
        run_op("illegal", 4'd9, 16'd1,    16'd2,   1, 32'd0,        1'b1, 1'b0);

        // MULT aborted by reset: no done pulse afterwards.
        @(negedge clk);
        command = 4'd3;
        inputA  = 16'd50;
        inputB  = 16'd60;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(1'b0));
        chk("abort_done", 64'(done), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("abort_nopulse", 64'(pulses), 64'(0));
        run_op("add_after", 4'd1, 16'd2, 16'd3, 1, 32'd5, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
